// File: rtl/tank_pkg.sv
// Shared widths, screen bounds, slot record and spawn FSM states
// for the tank bullet logic.
package tank_pkg;

  localparam int POS_W  = 17;
  localparam int VEL_W  = 11;
  localparam int FRAC   = 6;
  localparam int INT_W  = POS_W - FRAC;
  localparam int LIFE_W = 10;
  localparam int CD_W   = 8;

  localparam int SCR_X_MIN = 0;
  localparam int SCR_X_MAX = 639;
  localparam int SCR_Y_MIN = 0;
  localparam int SCR_Y_MAX = 479;

  typedef struct packed {
    logic                    active;
    logic signed [POS_W-1:0] x;
    logic signed [POS_W-1:0] y;
    logic signed [VEL_W-1:0] vx;
    logic signed [VEL_W-1:0] vy;
    logic [LIFE_W-1:0]       life;
  } bullet_slot_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_LOAD
  } spawn_state_t;

  function automatic logic signed [POS_W-1:0] vext(
    input logic signed [VEL_W-1:0] v
  );
    return {{(POS_W-VEL_W){v[VEL_W-1]}}, v};
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position/velocity/life registers and per-frame move.
// BULLET_BOUNCE_EN: reflect at the screen edge instead of retiring.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int LIFETIME = 600,
  parameter int X_MIN    = SCR_X_MIN,
  parameter int X_MAX    = SCR_X_MAX,
  parameter int Y_MIN    = SCR_Y_MIN,
  parameter int Y_MAX    = SCR_Y_MAX
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic                    clear,
  input  logic                    frame_tick,
  input  logic                    load,
  input  logic signed [POS_W-1:0] load_x,
  input  logic signed [POS_W-1:0] load_y,
  input  logic signed [VEL_W-1:0] load_vx,
  input  logic signed [VEL_W-1:0] load_vy,
  output logic                    active,
  output logic [9:0]              pos_x,
  output logic [9:0]              pos_y
);

  bullet_slot_t            slot;
  logic signed [POS_W-1:0] nx;
  logic signed [POS_W-1:0] ny;
  logic signed [INT_W-1:0] ix;
  logic signed [INT_W-1:0] iy;
  logic                    x_lo;
  logic                    x_hi;
  logic                    y_lo;
  logic                    y_hi;
  logic [LIFE_W-1:0]       life_n;
  logic                    alive;

  // next position, integer part and bound tests
  always_comb begin
    nx     = slot.x + vext(slot.vx);
    ny     = slot.y + vext(slot.vy);
    ix     = nx[POS_W-1:FRAC];
    iy     = ny[POS_W-1:FRAC];
    x_lo   = ix < $signed(INT_W'(X_MIN));
    x_hi   = ix > $signed(INT_W'(X_MAX));
    y_lo   = iy < $signed(INT_W'(Y_MIN));
    y_hi   = iy > $signed(INT_W'(Y_MAX));
    life_n = slot.life - LIFE_W'(1);
    alive  = life_n != '0;
  end

`ifdef BULLET_BOUNCE_EN
  localparam logic signed [POS_W-1:0] XLO2 = POS_W'((2 * X_MIN) << FRAC);
  localparam logic signed [POS_W-1:0] XHI2 = POS_W'((2 * X_MAX) << FRAC);
  localparam logic signed [POS_W-1:0] YLO2 = POS_W'((2 * Y_MIN) << FRAC);
  localparam logic signed [POS_W-1:0] YHI2 = POS_W'((2 * Y_MAX) << FRAC);

  logic signed [POS_W-1:0] bx;
  logic signed [POS_W-1:0] by;
  logic signed [VEL_W-1:0] bvx;
  logic signed [VEL_W-1:0] bvy;

  // mirror the crossed axis about the violated bound
  always_comb begin
    bx  = nx;
    by  = ny;
    bvx = slot.vx;
    bvy = slot.vy;
    if (x_hi) begin
      bx  = XHI2 - nx;
      bvx = -slot.vx;
    end else if (x_lo) begin
      bx  = XLO2 - nx;
      bvx = -slot.vx;
    end
    if (y_hi) begin
      by  = YHI2 - ny;
      bvy = -slot.vy;
    end else if (y_lo) begin
      by  = YLO2 - ny;
      bvy = -slot.vy;
    end
  end
`endif

  // slot state: clear, load, then per-frame movement
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      slot <= '0;
    end else if (clear) begin
      slot.active <= 1'b0;
    end else if (load) begin
      slot.active <= 1'b1;
      slot.x      <= load_x;
      slot.y      <= load_y;
      slot.vx     <= load_vx;
      slot.vy     <= load_vy;
      slot.life   <= LIFE_W'(LIFETIME);
    end else if (frame_tick && slot.active) begin
      slot.life <= life_n;
`ifdef BULLET_BOUNCE_EN
      slot.x      <= bx;
      slot.y      <= by;
      slot.vx     <= bvx;
      slot.vy     <= bvy;
      slot.active <= alive;
`else
      if (x_lo || x_hi || y_lo || y_hi) begin
        slot.active <= 1'b0;
      end else begin
        slot.x      <= nx;
        slot.y      <= ny;
        slot.active <= alive;
      end
`endif
    end
  end

  assign active = slot.active;
  assign pos_x  = slot.x[FRAC+9:FRAC];
  assign pos_y  = slot.y[FRAC+9:FRAC];

endmodule

// File: rtl/bullet_manager.sv
// Three-slot bullet pool for one tank: fire edge, cooldown, spawn FSM.
// BULLET_BOUNCE_EN (in bullet_slot) makes bullets bounce off edges.
module bullet_manager
  import tank_pkg::*;
#(
  parameter int SPEED       = 2,
  parameter int SPAWN_DIST  = 12,
  parameter int LIFETIME    = 600,
  parameter int COOLDOWN    = 15,
  parameter int BULLET_SIZE = 2,
  parameter int X_MIN       = SCR_X_MIN,
  parameter int X_MAX       = SCR_X_MAX,
  parameter int Y_MIN       = SCR_Y_MIN,
  parameter int Y_MAX       = SCR_Y_MAX
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              fire,
  input  logic              clear,
  input  logic [9:0]        TankX,
  input  logic [9:0]        TankY,
  input  logic signed [7:0] sin,
  input  logic signed [7:0] cos,
  output logic [9:0]        Bullet1X,
  output logic [9:0]        Bullet2X,
  output logic [9:0]        Bullet3X,
  output logic [9:0]        Bullet1Y,
  output logic [9:0]        Bullet2Y,
  output logic [9:0]        Bullet3Y,
  output logic [9:0]        Bullet1S,
  output logic [9:0]        Bullet2S,
  output logic [9:0]        Bullet3S,
  output logic              is_bullet1_active,
  output logic              is_bullet2_active,
  output logic              is_bullet3_active,
  output logic              fired
);

  spawn_state_t            state;
  logic [1:0]              sel;
  logic [1:0]              low_idx;
  logic [2:0]              act;
  logic [2:0]              free;
  logic [2:0]              low;
  logic [2:0]              load;
  logic                    fire_q;
  logic                    rise;
  logic [CD_W-1:0]         cd;
  logic signed [POS_W-1:0] px;
  logic signed [POS_W-1:0] py;
  logic signed [VEL_W-1:0] vx;
  logic signed [VEL_W-1:0] vy;
  logic signed [POS_W-1:0] cos_off;
  logic signed [POS_W-1:0] sin_off;
  logic [9:0]              bx [3];
  logic [9:0]              by [3];

  assign free    = ~act;
  assign low     = free & (~free + 3'd1);
  assign rise    = fire & ~fire_q;
  assign cos_off = POS_W'(cos * SPAWN_DIST);
  assign sin_off = POS_W'(sin * SPAWN_DIST);

  // lowest-index free slot
  always_comb begin
    low_idx = 2'd0;
    unique case (1'b1)
      low[0]:  low_idx = 2'd0;
      low[1]:  low_idx = 2'd1;
      low[2]:  low_idx = 2'd2;
      default: low_idx = 2'd0;
    endcase
  end

  // fire edge, cooldown and spawn sequencing
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      sel    <= 2'd0;
      px     <= '0;
      py     <= '0;
      vx     <= '0;
      vy     <= '0;
      fired  <= 1'b0;
      cd     <= '0;
      fire_q <= 1'b1;
    end else begin
      fire_q <= fire;
      fired  <= 1'b0;
      if (frame_tick && cd != '0)
        cd <= cd - CD_W'(1);
      if (clear) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (rise && cd == '0 && |free)
              state <= S_CALC;
          end
          S_CALC: begin
            sel   <= low_idx;
            px    <= $signed({1'b0, TankX, 6'b0}) + cos_off;
            py    <= $signed({1'b0, TankY, 6'b0}) + sin_off;
            vx    <= VEL_W'(cos * SPEED);
            vy    <= VEL_W'(sin * SPEED);
            state <= S_LOAD;
          end
          S_LOAD: begin
            fired <= 1'b1;
            cd    <= CD_W'(COOLDOWN);
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_slot
    assign load[k] = (state == S_LOAD) && !clear
                   && (sel == 2'(k));

    bullet_slot #(
      .LIFETIME (LIFETIME),
      .X_MIN    (X_MIN),
      .X_MAX    (X_MAX),
      .Y_MIN    (Y_MIN),
      .Y_MAX    (Y_MAX)
    ) u_slot (
      .CLK        (CLK),
      .Reset_n    (Reset_n),
      .clear      (clear),
      .frame_tick (frame_tick),
      .load       (load[k]),
      .load_x     (px),
      .load_y     (py),
      .load_vx    (vx),
      .load_vy    (vy),
      .active     (act[k]),
      .pos_x      (bx[k]),
      .pos_y      (by[k])
    );
  end

  assign Bullet1X = bx[0];
  assign Bullet2X = bx[1];
  assign Bullet3X = bx[2];
  assign Bullet1Y = by[0];
  assign Bullet2Y = by[1];
  assign Bullet3Y = by[2];
  assign Bullet1S = 10'(BULLET_SIZE);
  assign Bullet2S = 10'(BULLET_SIZE);
  assign Bullet3S = 10'(BULLET_SIZE);

  assign is_bullet1_active = act[0];
  assign is_bullet2_active = act[1];
  assign is_bullet3_active = act[2];

endmodule

// File: tb/tb_bullet_manager.sv
// Directed bench for bullet_manager: spawn, cooldown, allocation,
// retire, clear, edge and lifetime.
module tb_bullet_manager;

  logic              CLK;
  logic              Reset_n;
  logic              frame_tick;
  logic              fire;
  logic              fire_l;
  logic              clear;
  logic [9:0]        TankX;
  logic [9:0]        TankY;
  logic signed [7:0] sin;
  logic signed [7:0] cos;

  logic [9:0] b1x, b2x, b3x, b1y, b2y, b3y;
  logic [9:0] b1s, b2s, b3s;
  logic       a1, a2, a3, fired;

  logic [9:0] l1x, l2x, l3x, l1y, l2y, l3y;
  logic [9:0] l1s, l2s, l3s;
  logic       la1, la2, la3, lfired;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic seen;

  bullet_manager u_dut (
    .CLK               (CLK),
    .Reset_n           (Reset_n),
    .frame_tick        (frame_tick),
    .fire              (fire),
    .clear             (clear),
    .TankX             (TankX),
    .TankY             (TankY),
    .sin               (sin),
    .cos               (cos),
    .Bullet1X          (b1x),
    .Bullet2X          (b2x),
    .Bullet3X          (b3x),
    .Bullet1Y          (b1y),
    .Bullet2Y          (b2y),
    .Bullet3Y          (b3y),
    .Bullet1S          (b1s),
    .Bullet2S          (b2s),
    .Bullet3S          (b3s),
    .is_bullet1_active (a1),
    .is_bullet2_active (a2),
    .is_bullet3_active (a3),
    .fired             (fired)
  );

  bullet_manager #(.LIFETIME(3)) u_life (
    .CLK               (CLK),
    .Reset_n           (Reset_n),
    .frame_tick        (frame_tick),
    .fire              (fire_l),
    .clear             (clear),
    .TankX             (TankX),
    .TankY             (TankY),
    .sin               (sin),
    .cos               (cos),
    .Bullet1X          (l1x),
    .Bullet2X          (l2x),
    .Bullet3X          (l3x),
    .Bullet1Y          (l1y),
    .Bullet2Y          (l2y),
    .Bullet3Y          (l3y),
    .Bullet1S          (l1s),
    .Bullet2S          (l2s),
    .Bullet3S          (l3s),
    .is_bullet1_active (la1),
    .is_bullet2_active (la2),
    .is_bullet3_active (la3),
    .fired             (lfired)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic ticks(input int cnt);
    repeat (cnt) begin
      frame_tick = 1'b1;
      @(negedge CLK);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    fire       = 1'b1;
    fire_l     = 1'b0;
    clear      = 1'b0;
    TankX      = 10'd0;
    TankY      = 10'd0;
    sin        = 8'sd0;
    cos        = 8'sd0;

    // reset, fire held through it
    repeat (3) @(negedge CLK);
    chk("rst_a1", a1, 0);
    chk("rst_x1", b1x, 0);
    chk("rst_s1", b1s, 2);
    chk("rst_s3", b3s, 2);
    chk("rst_fired", fired, 0);
    Reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      seen |= fired;
    end
    chk("held_fire_a1", a1, 0);
    chk("held_fire_fired", seen, 0);
    fire = 1'b0;
    @(negedge CLK);

    // spawn, tick in the same cycle as the press
    TankX = 10'd320;
    TankY = 10'd240;
    cos   = 8'sd64;
    sin   = 8'sd0;
    fire  = 1'b1;
    frame_tick = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
    @(negedge CLK);
    chk("spawn_lat_a1", a1, 0);
    @(negedge CLK);
    chk("spawn_a1", a1, 1);
    chk("spawn_fired", fired, 1);
    chk("spawn_x1", b1x, 332);
    chk("spawn_y1", b1y, 240);
    @(negedge CLK);
    chk("fired_pulse", fired, 0);
    fire = 1'b0;
    ticks(1);
    chk("move_x1", b1x, 334);

    // press during cooldown is ignored
    ticks(4);
    fire = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      seen |= fired;
    end
    fire = 1'b0;
    chk("cd_a2", a2, 0);
    chk("cd_fired", seen, 0);

    // after 15 frames a press spawns, heading up
    cos = 8'sd0;
    sin = -8'sd64;
    ticks(10);
    fire = 1'b1;
    repeat (3) @(negedge CLK);
    chk("cd_done_a2", a2, 1);
    chk("cd_done_fired", fired, 1);
    chk("slot2_x", b2x, 320);
    chk("slot2_y", b2y, 228);
    chk("slot1_x15", b1x, 362);
    fire = 1'b0;

    // third slot, fractional heading
    ticks(15);
    chk("slot2_y15", b2y, 198);
    cos = 8'sd45;
    sin = 8'sd45;
    fire = 1'b1;
    repeat (3) @(negedge CLK);
    chk("slot3_a3", a3, 1);
    chk("slot3_x", b3x, 328);
    chk("slot3_y", b3y, 248);
    fire = 1'b0;
    ticks(1);
    chk("slot3_x1", b3x, 329);
    chk("slot3_y1", b3y, 249);
    ticks(14);

    // all full: fourth press gives nothing
    fire = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      seen |= fired;
    end
    fire = 1'b0;
    chk("full_fired", seen, 0);

    // slot 2 leaves the top edge after 85 frames
    n = 0;
    while (a2 && n < 200) begin
      ticks(1);
      n++;
    end
    chk("retire_ticks", n, 85);
    chk("retire_a1", a1, 1);
    chk("retire_a3", a3, 1);
    chk("slot1_x_late", b1x, 592);
    chk("slot3_x_late", b3x, 469);
    chk("slot3_y_late", b3y, 389);

    // freed slot 2 is reused
    fire = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reuse_a2", a2, 1);
    chk("reuse_fired", fired, 1);
    chk("reuse_x2", b2x, 328);
    chk("reuse_y2", b2y, 248);
    fire = 1'b0;

    // clear kills everything next cycle
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    chk("clear_a1", a1, 0);
    chk("clear_a2", a2, 0);
    chk("clear_a3", a3, 0);

    // clear during S_LOAD wins
    ticks(15);
    fire = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    clear = 1'b1;
    @(negedge CLK);
    chk("clr_load_a1", a1, 0);
    chk("clr_load_fired", fired, 0);
    clear = 1'b0;
    fire  = 1'b0;
    @(negedge CLK);
    chk("clr_load_a1b", a1, 0);
    fire = 1'b1;
    repeat (3) @(negedge CLK);
    chk("clr_no_cd_a1", a1, 1);
    fire = 1'b0;

    // right edge
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    ticks(15);
    TankX = 10'd625;
    TankY = 10'd240;
    cos   = 8'sd64;
    sin   = 8'sd0;
    fire  = 1'b1;
    repeat (3) @(negedge CLK);
    chk("edge_x0", b1x, 637);
    fire = 1'b0;
    ticks(1);
    chk("edge_x1", b1x, 639);
    chk("edge_a1", a1, 1);
    ticks(1);
`ifdef BULLET_BOUNCE_EN
    chk("bounce_a1", a1, 1);
    chk("bounce_x", b1x, 637);
    ticks(1);
    chk("bounce_x2", b1x, 635);
`else
    chk("edge_gone", a1, 0);
`endif

    // lifetime of 3 frames
    TankX  = 10'd320;
    fire_l = 1'b1;
    repeat (3) @(negedge CLK);
    chk("life_a1", la1, 1);
    chk("life_fired", lfired, 1);
    chk("life_x", l1x, 332);
    fire_l = 1'b0;
    ticks(1);
    chk("life_t1", la1, 1);
    ticks(1);
    chk("life_t2", la1, 1);
    chk("life_x2", l1x, 336);
    ticks(1);
    chk("life_t3", la1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
